// File: rtl/pixel_mixer.sv
`default_nettype none
// =============================================================================
// Module   : pixel_mixer
// Brief    : Aligns layer flags with ROM pixels, applies the colour key and layer
//            priority, expands RRRGGGBB to 12-bit RGB and delays syncs to match.
//            The collision counter is built only with PIXEL_MIXER_COLLISION_EN.
// Revision : 1.0
// =============================================================================
module pixel_mixer #(
  parameter int         SPRITE_LAT  = 1,
  parameter logic [7:0] TRANSPARENT = 8'hE3,
  parameter logic [7:0] BOX_COLOR   = 8'hFF,
  parameter logic [7:0] BG_COLOR    = 8'h00
) (
  input  logic        Pclk,
  input  logic        rst_n,
  input  logic        aactive,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        characterOn,
  input  logic [7:0]  character_dataout,
  input  logic        bulletOn,
  input  logic [7:0]  bullet_dataout,
  input  logic        boxOn,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        hit,
  output logic [7:0]  frame_hits
);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic chr;
    logic bul;
    logic box;
  } flags_t;

  // Sync lines idle high, so their stages come out of reset at 1.
  localparam flags_t FLAGS_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1,
                                   chr: 1'b0, bul: 1'b0, box: 1'b0};

  flags_t [SPRITE_LAT-1:0] dly_d, dly_q;
  flags_t                  lat;

  logic        spr_opaque;
  logic        bul_opaque;
  logic [7:0]  pix;
  logic [11:0] rgb_d, rgb_q;
  logic        hsync_d, hsync_q;
  logic        vsync_d, vsync_q;

  function automatic logic [11:0] expand(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

  always_comb begin
    dly_d[0] = '{act: aactive, hs: hsync_in, vs: vsync_in,
                 chr: characterOn, bul: bulletOn, box: boxOn};
    for (int i = 1; i < SPRITE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  assign lat = dly_q[SPRITE_LAT-1];

  // Pixel data arrives undelayed; it already lines up with the delayed flags.
  always_comb begin
    spr_opaque = lat.chr && (character_dataout != TRANSPARENT);
    bul_opaque = lat.bul && (bullet_dataout != TRANSPARENT);
    if (spr_opaque) begin
      pix = character_dataout;
    end else if (bul_opaque) begin
      pix = bullet_dataout;
    end else if (lat.box) begin
      pix = BOX_COLOR;
    end else begin
      pix = BG_COLOR;
    end
    rgb_d   = lat.act ? expand(pix) : 12'h000;
    hsync_d = lat.hs;
    vsync_d = lat.vs;
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPRITE_LAT; i++) begin
        dly_q[i] <= FLAGS_RST;
      end
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      dly_q   <= dly_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

`ifdef PIXEL_MIXER_COLLISION_EN
  logic       hit_d, hit_q;
  logic       vs_fall;
  logic [7:0] hit_cnt_d, hit_cnt_q;
  logic [7:0] frame_hits_d, frame_hits_q;

  // vsync_q holds the previous delayed vsync, giving the frame edge for free.
  always_comb begin
    hit_d        = lat.act && spr_opaque && bul_opaque;
    vs_fall      = vsync_q && !lat.vs;
    hit_cnt_d    = hit_cnt_q;
    frame_hits_d = frame_hits_q;
    if (vs_fall) begin
      frame_hits_d = hit_cnt_q;
      hit_cnt_d    = {7'd0, hit_d};
    end else if (hit_d && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q        <= 1'b0;
      hit_cnt_q    <= 8'h00;
      frame_hits_q <= 8'h00;
    end else begin
      hit_q        <= hit_d;
      hit_cnt_q    <= hit_cnt_d;
      frame_hits_q <= frame_hits_d;
    end
  end

  assign hit        = hit_q;
  assign frame_hits = frame_hits_q;
`else
  assign hit        = 1'b0;
  assign frame_hits = 8'h00;
`endif

endmodule
`default_nettype wire

// File: doc/pixel_mixer.md
Name: pixel_mixer

Overview:
- Downstream of the character sprite renderer and the other layer renderers.
- Aligns each layer's on-flag with that layer's ROM pixel data, applies a transparency key and fixed layer priority, expands 8-bit RRRGGGBB pixels to 12-bit RGB, and delays syncs to match.
- Drives the VGA pins directly; one pixel clock domain.

Parameters:
- SPRITE_LAT, 1, cycles by which *_dataout lags its *On flag (ROM read latency); legal 1..4
- TRANSPARENT, 8'hE3, colour key; sprite/bullet pixels equal to this are not drawn
- BOX_COLOR, 8'hFF, colour of box layer
- BG_COLOR, 8'h00, background colour inside active area

Ports:
- Pclk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- aactive  input  1  active video from timing generator, same cycle as xx/yy
- hsync_in  input  1  horizontal sync, active low
- vsync_in  input  1  vertical sync, active low
- characterOn  input  1  sprite layer coverage
- character_dataout  input  8  sprite pixel, RRRGGGBB, lags characterOn by SPRITE_LAT
- bulletOn  input  1  bullet layer coverage
- bullet_dataout  input  8  bullet pixel, RRRGGGBB, lags bulletOn by SPRITE_LAT
- boxOn  input  1  box-border layer coverage, no data
- rgb  output  12  {R[3:0],G[3:0],B[3:0]} to VGA DAC
- hsync  output  1  delayed hsync_in
- vsync  output  1  delayed vsync_in
- hit  output  1  one-cycle collision pulse
- frame_hits  output  8  collisions counted in previous frame

Behaviour:
- Clocking and reset:
  - Single clock Pclk; asynchronous active-low reset rst_n.
  - Reset values: rgb=0, hsync=1, vsync=1, hit=0, frame_hits=0, all pipeline registers 0 (sync stages 1).
- Alignment stage:
  - Shift registers of depth SPRITE_LAT on aactive, hsync_in, vsync_in, characterOn, bulletOn, boxOn.
  - Data inputs are sampled undelayed. Delayed flags then coincide with their pixel data.
- Decision: a layer is opaque when its delayed On=1 and, for sprite/bullet, data != TRANSPARENT.
- Priority: sprite > bullet > box > BG_COLOR.
- Blanking: delayed aactive=0 forces colour 0 regardless of layers.
- Output stage:
  - Registered.
  - Total latency from any input to rgb/hsync/vsync = SPRITE_LAT+1 cycles.
  - Syncs and rgb always stay mutually aligned.
- Colour expansion for 8-bit c:
  - R4={c[7:5],c[7]}
  - G4={c[4:2],c[4]}
  - B4={c[1:0],c[1:0]}
  - So 8'hFF -> 12'hFFF and 8'h00 -> 12'h000.
- Reset mid-frame: outputs take reset values immediately. After release, the pipeline refills and the first SPRITE_LAT+1 output cycles reflect reset contents (rgb=0, syncs=1).
- No handshake: one pixel in and one pixel out every Pclk cycle, with no stalls.

Optional Feature:
- Macro PIXEL_MIXER_COLLISION_EN.
- Defined:
  - hit is registered alongside rgb and pulses 1 on cycles where delayed aactive=1 and sprite and bullet are both opaque.
  - A per-frame counter increments on hit and saturates at 255.
  - On the falling edge of the delayed vsync (1->0), frame_hits <= counter and the counter clears.
  - If hit coincides with that edge, the counter is set to 1 (the hit belongs to the new frame).
- Undefined: hit and frame_hits are tied to 0, and no counter logic is present. rgb/sync behaviour is identical in both builds.

Test Plan:
- Reset, then aactive=1 with no layers on -> after 2 cycles (SPRITE_LAT=1), rgb=12'h000 (BG_COLOR 8'h00); hsync/vsync=1 during reset.
- characterOn=1, character_dataout=8'hE0 one cycle later -> rgb=12'hF00 exactly 2 cycles after characterOn rose.
- Sprite data=8'hE3 (key) with boxOn=1 -> rgb=12'hFFF (box shows through). Same pixel with aactive=0 -> rgb=12'h000.
- Sprite 8'h1C over bullet 8'h03, both on -> rgb=12'h0F0. Collision build: hit=1 for that cycle only.
- Collision build: 300 overlapping pixels in one frame, then vsync falling edge -> frame_hits=255 (saturated) and the counter restarts. Next frame with 0 hits -> frame_hits=0.
- Assert rst_n low mid-line -> rgb=0 and syncs=1 within the same cycle. Release -> valid pixels resume after 2 cycles with sync alignment preserved.
